// File: rtl/data_sram_responder.sv
// Data SRAM port target: 1-cycle-latency word RAM plus an MMIO page (free-running timer, LED register).
// Optional build macro DATA_SRAM_ACC_CNT_EN adds saturating RAM read/write access counters to the MMIO page.
module data_sram_responder #(
  parameter int unsigned RAM_AW    = 12,
  parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000,
  parameter logic [15:0] TIMER_OFF = 16'hE000,
  parameter logic [15:0] LED_OFF   = 16'hF000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led
);

  localparam int unsigned DEPTH = 1 << RAM_AW;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       timer;
  logic [31:0]       timer_inc;
  logic [31:0]       ram_rdata;
  logic [31:0]       mmio_rdata;
  logic [15:0]       off;
  logic [RAM_AW-1:0] ram_idx;
  logic              is_mmio;
  logic              acc_rd;
  logic              acc_wr;
  logic              ram_rd;
  logic              ram_wr;
  logic              hit_timer;
  logic              hit_led;
  logic              unused_addr_lsb;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return res;
  endfunction

  assign is_mmio         = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign off             = data_sram_addr[15:0];
  assign ram_idx         = data_sram_addr[RAM_AW+1:2];
  assign unused_addr_lsb = ^data_sram_addr[1:0];

  assign acc_rd = data_sram_en && (data_sram_we == 4'b0000);
  assign acc_wr = data_sram_en && (data_sram_we != 4'b0000);
  assign ram_rd = acc_rd && !is_mmio;
  assign ram_wr = acc_wr && !is_mmio;

  assign hit_timer = is_mmio && (off == TIMER_OFF);
  assign hit_led   = is_mmio && (off == LED_OFF);
  assign timer_inc = timer + 32'd1;

`ifdef DATA_SRAM_ACC_CNT_EN
  localparam logic [15:0] RD_CNT_OFF = TIMER_OFF + 16'h0010;
  localparam logic [15:0] WR_CNT_OFF = TIMER_OFF + 16'h0014;

  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic        hit_rd_cnt;
  logic        hit_wr_cnt;

  assign hit_rd_cnt = is_mmio && (off == RD_CNT_OFF);
  assign hit_wr_cnt = is_mmio && (off == WR_CNT_OFF);

  // A write to a counter clears it and takes priority over a count in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_cnt <= 32'd0;
      wr_cnt <= 32'd0;
    end else begin
      if (acc_wr && hit_rd_cnt)
        rd_cnt <= 32'd0;
      else if (ram_rd && (rd_cnt != 32'hFFFF_FFFF))
        rd_cnt <= rd_cnt + 32'd1;

      if (acc_wr && hit_wr_cnt)
        wr_cnt <= 32'd0;
      else if (ram_wr && (wr_cnt != 32'hFFFF_FFFF))
        wr_cnt <= wr_cnt + 32'd1;
    end
  end
`endif

  always_comb begin
    mmio_rdata = 32'h0;
    if (hit_timer)
      mmio_rdata = timer;
    else if (hit_led)
      mmio_rdata = {16'h0, led};
`ifdef DATA_SRAM_ACC_CNT_EN
    else if (hit_rd_cnt)
      mmio_rdata = rd_cnt;
    else if (hit_wr_cnt)
      mmio_rdata = wr_cnt;
`endif
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int i = 0; i < 4; i++)
        if (data_sram_we[i])
          mem[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
    end
  end

  assign ram_rdata = mem[ram_idx];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      data_sram_rdata <= 32'h0;
    else if (acc_rd)
      data_sram_rdata <= is_mmio ? mmio_rdata : ram_rdata;
  end

  // Unwritten timer bytes continue from the incremented value so a partial write does not stall the count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      timer <= 32'h0;
    else if (acc_wr && hit_timer)
      timer <= byte_merge(timer_inc, data_sram_wdata, data_sram_we);
    else
      timer <= timer_inc;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led <= 16'h0000;
    end else if (acc_wr && hit_led) begin
      if (data_sram_we[0]) led[7:0]  <= data_sram_wdata[7:0];
      if (data_sram_we[1]) led[15:8] <= data_sram_wdata[15:8];
    end
  end

endmodule
